// File: rtl/physics_scheduler_pkg.sv
// physics_scheduler_pkg: shared types and constants for the physics frame sequencer.
package physics_scheduler_pkg;
    localparam int DEF_NUM_PINS = 10;
    localparam int VEL_W = 16;
    typedef enum logic [2:0] {IDLE, WAIT_TICK, COLL_REQ, COLL_WAIT, STEP} physics_sched_state_t;
    function automatic logic [3:0] popcount16(input logic [15:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {3'b0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/physics_scheduler_frame_timer.sv
// physics_scheduler_frame_timer: free-running frame tick counter, held at zero while run is low.
module physics_scheduler_frame_timer #(
    parameter int FRAME_CYCLES = 750000
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic run_in,
    output logic tick_out
);
    localparam int CW = $clog2(FRAME_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick_out = run_in && cnt_q == CW'(FRAME_CYCLES - 1);
    always_comb cnt_d = (!run_in || tick_out) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/physics_scheduler.sv
// physics_scheduler: sequences one collision evaluation per physics frame and hands results to the integrator.
module physics_scheduler
    import physics_scheduler_pkg::*;
#(
    parameter int NUM_PINS     = DEF_NUM_PINS,
    parameter int FRAME_CYCLES = 750000,
    parameter int COLL_TIMEOUT = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      run_in,
    input  logic                      clear_in,
    output logic                      coll_start_out,
    input  logic                      coll_done_in,
    input  logic [NUM_PINS-1:0]       coll_hit_in,
    input  logic [NUM_PINS*VEL_W-1:0] coll_vx_in,
    input  logic [NUM_PINS*VEL_W-1:0] coll_vy_in,
    output logic                      step_valid_out,
    input  logic                      step_ready_in,
    output logic [NUM_PINS*VEL_W-1:0] pins_vx_out,
    output logic [NUM_PINS*VEL_W-1:0] pins_vy_out,
    output logic [NUM_PINS-1:0]       hit_mask_out,
    output logic [3:0]                hit_count_out,
    output logic [15:0]               frame_count_out,
    output logic                      overrun_out,
    output logic                      timeout_out,
    output logic                      busy_out
);
    localparam int WW = $clog2(COLL_TIMEOUT + 1);
    physics_sched_state_t      state_q, state_d;
    logic [WW-1:0]             wait_q, wait_d;
    logic [NUM_PINS*VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [NUM_PINS-1:0]       mask_q, mask_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [15:0]               frame_q, frame_d;
    logic                      ovr_q, ovr_d, tmo_q, tmo_d;
    logic                      tick, done;

    physics_scheduler_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .run_in   (run_in),
        .tick_out (tick)
    );

    assign done = state_q == COLL_WAIT && coll_done_in;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        mask_d  = mask_q;
        frame_d = frame_q;
        ovr_d   = ovr_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE:      state_d = run_in ? WAIT_TICK : IDLE;
            WAIT_TICK: state_d = tick ? COLL_REQ : (run_in ? WAIT_TICK : IDLE);
            COLL_REQ: begin
                state_d = COLL_WAIT;
                wait_d  = '0;
            end
            COLL_WAIT: begin
                if (coll_done_in) begin
                    state_d = STEP;
                    mask_d  = mask_q | coll_hit_in;
                end else if (wait_q == WW'(COLL_TIMEOUT - 1)) begin
                    state_d = WAIT_TICK;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            STEP: begin
                if (step_ready_in) begin
                    frame_d = frame_q + 16'd1;
                    state_d = run_in ? WAIT_TICK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Unhit pins keep their last captured velocity.
        for (int i = 0; i < NUM_PINS; i++) begin
            if (done && coll_hit_in[i]) begin
                vx_d[i*VEL_W +: VEL_W] = coll_vx_in[i*VEL_W +: VEL_W];
                vy_d[i*VEL_W +: VEL_W] = coll_vy_in[i*VEL_W +: VEL_W];
            end
        end
        if (tick && state_q != WAIT_TICK) ovr_d = 1'b1;
        if (clear_in) begin
            mask_d  = '0;
            frame_d = '0;
            ovr_d   = 1'b0;
            tmo_d   = 1'b0;
        end
        cnt_d = popcount16(16'(mask_d));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            wait_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign coll_start_out  = state_q == COLL_REQ;
    assign step_valid_out  = state_q == STEP;
    assign busy_out        = state_q == COLL_REQ || state_q == COLL_WAIT || state_q == STEP;
    assign pins_vx_out     = vx_q;
    assign pins_vy_out     = vy_q;
    assign hit_mask_out    = mask_q;
    assign hit_count_out   = cnt_q;
    assign frame_count_out = frame_q;
    assign overrun_out     = ovr_q;
    assign timeout_out     = tmo_q;
endmodule

// File: tb/tb_physics_scheduler.sv
// tb_physics_scheduler: directed self-checking bench for physics_scheduler with FRAME_CYCLES=8, COLL_TIMEOUT=4.
module tb_physics_scheduler;
    localparam int NP = 10;
    logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, clear = 1'b0, done = 1'b0, ready = 1'b1;
    logic resp_en = 1'b1;
    logic [NP-1:0] hit = '0;
    logic [NP*16-1:0] cvx = '0, cvy = '0;
    logic start, valid, ovr, tmo, busy;
    logic [NP*16-1:0] pvx, pvy;
    logic [NP-1:0] mask;
    logic [3:0] hcnt;
    logic [15:0] fcnt;
    int cyc = 0, n_cmp = 0, n_err = 0, last = 0, cnt = 0;

    physics_scheduler #(.NUM_PINS(NP), .FRAME_CYCLES(8), .COLL_TIMEOUT(4)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .run_in          (run),
        .clear_in        (clear),
        .coll_start_out  (start),
        .coll_done_in    (done),
        .coll_hit_in     (hit),
        .coll_vx_in      (cvx),
        .coll_vy_in      (cvy),
        .step_valid_out  (valid),
        .step_ready_in   (ready),
        .pins_vx_out     (pvx),
        .pins_vy_out     (pvy),
        .hit_mask_out    (mask),
        .hit_count_out   (hcnt),
        .frame_count_out (fcnt),
        .overrun_out     (ovr),
        .timeout_out     (tmo),
        .busy_out        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Collision model: done pulse two cycles after each start pulse.
    initial forever begin
        @(negedge clk);
        if (start && resp_en) begin
            repeat (2) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 40 && !start; i++) @(negedge clk);
        check(tag, 32'(start), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !valid; i++) @(negedge clk);
        check(tag, 32'(valid), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({start, valid, busy, ovr, tmo}), 32'd0);
        check({tag, "_mask"}, 32'(mask), 32'd0);
        check({tag, "_cnt"}, 32'(hcnt), 32'd0);
        check({tag, "_frame"}, 32'(fcnt), 32'd0);
        check({tag, "_vel"}, 32'(|{pvx, pvy}), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("rst");
        hit = 10'h005;
        cvx[0 +: 16] = 16'h0040;
        cvx[32 +: 16] = 16'h0123;
        cvy[0 +: 16] = 16'h0011;
        rst_n = 1'b1;
        run = 1'b1;
        last = cyc;
        wait_start("f1_start");
        check("f1_first_start", 32'(cyc - last), 32'd8);
        last = cyc;
        wait_valid("f1_valid");
        check("f1_latency", 32'(cyc - last), 32'd3);
        check("f1_vx0", 32'(pvx[0 +: 16]), 32'h0040);
        check("f1_vx2", 32'(pvx[32 +: 16]), 32'h0123);
        check("f1_vy0", 32'(pvy[0 +: 16]), 32'h0011);
        check("f1_mask", 32'(mask), 32'h005);
        check("f1_cnt", 32'(hcnt), 32'd2);
        @(negedge clk);
        check("f1_frame", 32'(fcnt), 32'd1);
        check("f1_valid_drop", 32'(valid), 32'd0);
        hit = 10'h004;
        cvx[0 +: 16] = 16'hBEEF;
        cvx[32 +: 16] = 16'h0222;
        wait_start("f2_start");
        check("f2_period", 32'(cyc - last), 32'd8);
        last = cyc;
        wait_valid("f2_valid");
        check("f2_mask", 32'(mask), 32'h005);
        check("f2_vx0", 32'(pvx[0 +: 16]), 32'h0040);
        check("f2_vx2", 32'(pvx[32 +: 16]), 32'h0222);
        check("f2_cnt", 32'(hcnt), 32'd2);
        hit = 10'h200;
        cvx[144 +: 16] = 16'h0999;
        wait_start("f3_start");
        check("f3_period", 32'(cyc - last), 32'd8);
        last = cyc;
        wait_valid("f3_valid");
        check("f3_mask", 32'(mask), 32'h205);
        check("f3_cnt", 32'(hcnt), 32'd3);
        check("f3_vx9", 32'(pvx[144 +: 16]), 32'h0999);
        @(negedge clk);
        check("f3_frame", 32'(fcnt), 32'd3);
        ready = 1'b0;
        hit = 10'h001;
        cvx[0 +: 16] = 16'h0077;
        wait_start("bp_start");
        last = cyc;
        wait_valid("bp_valid_rise");
        repeat (12) begin
            @(negedge clk);
            check("bp_valid_hold", 32'(valid), 32'd1);
            check("bp_vx0_hold", 32'(pvx[0 +: 16]), 32'h0077);
            check("bp_mask_hold", 32'(mask), 32'h205);
        end
        check("bp_overrun", 32'(ovr), 32'd1);
        check("bp_frame_held", 32'(fcnt), 32'd3);
        ready = 1'b1;
        @(negedge clk);
        check("bp_frame_inc", 32'(fcnt), 32'd4);
        check("bp_valid_drop", 32'(valid), 32'd0);
        resp_en = 1'b0;
        @(negedge clk);
        check("bp_frame_once", 32'(fcnt), 32'd4);
        wait_start("to_start");
        last = cyc;
        cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (valid) cnt++;
            if (i == 4) check("to_not_yet", 32'(tmo), 32'd0);
        end
        check("to_flag", 32'(tmo), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_valid", 32'(cnt), 32'd0);
        check("to_frame", 32'(fcnt), 32'd4);
        resp_en = 1'b1;
        hit = 10'h002;
        wait_start("to_next_start");
        check("to_next_period", 32'(cyc - last), 32'd8);
        last = cyc;
        wait_valid("f6_valid");
        check("f6_mask", 32'(mask), 32'h207);
        check("f6_cnt", 32'(hcnt), 32'd4);
        @(negedge clk);
        check("f6_frame", 32'(fcnt), 32'd5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_mask", 32'(mask), 32'd0);
        check("clr_cnt", 32'(hcnt), 32'd0);
        check("clr_frame", 32'(fcnt), 32'd0);
        check("clr_flags", 32'({ovr, tmo}), 32'd0);
        check("clr_vx0_kept", 32'(pvx[0 +: 16]), 32'h0077);
        wait_start("clr_start");
        check("clr_period", 32'(cyc - last), 32'd8);
        last = cyc;
        hit = 10'h008;
        cvx[48 +: 16] = 16'h0333;
        @(negedge clk);
        run = 1'b0;
        wait_valid("stop_valid");
        check("stop_latency", 32'(cyc - last), 32'd3);
        check("stop_mask", 32'(mask), 32'h008);
        check("stop_cnt", 32'(hcnt), 32'd1);
        check("stop_vx3", 32'(pvx[48 +: 16]), 32'h0333);
        @(negedge clk);
        check("stop_frame", 32'(fcnt), 32'd1);
        check("stop_idle", 32'(busy), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (start) cnt++;
        end
        check("stop_no_start", 32'(cnt), 32'd0);
        ready = 1'b0;
        hit = 10'h010;
        run = 1'b1;
        last = cyc;
        wait_start("ar_start");
        check("ar_run_start", 32'(cyc - last), 32'd8);
        wait_valid("ar_valid");
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        last = cyc;
        wait_start("ar_rel_start");
        check("ar_rel_delay", 32'(cyc - last), 32'd8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/physics_scheduler.md
# physics_scheduler

Frame-rate sequencer for the bowling physics datapath. Generates the physics frame tick and starts one collision evaluation per frame. It latches the resulting pin velocities and sticky hit mask, then hands the frame off to the position integrator with a valid/ready handshake. It sits between the top-level game control and the collision and integrator blocks, replacing free-running timers inside those blocks.

## Interface
Parameters:
- NUM_PINS, 10, number of pins
- FRAME_CYCLES, 750000, clock cycles per physics frame (≥ 4)
- COLL_TIMEOUT, 64, max cycles to wait for collision done (≥ 1)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- run_in  input  1  level; enables frame ticks
- clear_in  input  1  sync pulse; clears hit mask, counters, sticky flags
- coll_start_out  output  1  one-cycle start pulse to the collision block
- coll_done_in  input  1  one-cycle pulse, collision results valid
- coll_hit_in  input  NUM_PINS  per-pin hit flags from the collision block
- coll_vx_in / coll_vy_in  input  NUM_PINS×16  per-pin velocities from the collision block
- step_valid_out  output  1  frame ready for the integrator
- step_ready_in  input  1  integrator accepts
- pins_vx_out / pins_vy_out  output  NUM_PINS×16  latched pin velocities
- hit_mask_out  output  NUM_PINS  sticky OR of all latched coll_hit_in
- hit_count_out  output  4  popcount of hit_mask_out
- frame_count_out  output  16  completed frames, wraps at 0xFFFF→0
- overrun_out  output  1  sticky: a tick arrived while busy
- timeout_out  output  1  sticky: collision did not respond in time
- busy_out  output  1  high in states COLL_REQ, COLL_WAIT, STEP

## Operation
- Reset: every output is 0, the state is IDLE, and the tick counter is 0.
- Tick counter: counts while run_in=1. It asserts an internal tick when it is at FRAME_CYCLES-1, then wraps to 0. It is held at 0 while run_in=0.
- States:
  - IDLE: on run_in=1, go to WAIT_TICK.
  - WAIT_TICK: on tick, go to COLL_REQ. If run_in=0, go to IDLE.
  - COLL_REQ: coll_start_out=1 for exactly this cycle. Go to COLL_WAIT and clear the wait counter.
  - COLL_WAIT: coll_done_in is sampled only in this state.
    - On done: for each pin with coll_hit_in[i]=1, capture coll_vx_in[i] and coll_vy_in[i]; pins not hit keep their prior values. Set hit_mask |= coll_hit_in and go to STEP.
    - If the wait counter reaches COLL_TIMEOUT without done: set timeout_out, go to WAIT_TICK, and do not increment frame_count.
  - STEP: step_valid_out=1 and held until step_ready_in=1 is sampled. Then frame_count increments and the state goes to WAIT_TICK (or IDLE if run_in=0).
- Deasserting run_in mid-frame does not abort the frame; the in-flight frame completes.
- A tick in any state other than WAIT_TICK is dropped and sets overrun_out.
- clear_in zeroes hit_mask, hit_count, frame_count, overrun and timeout. It does not change the state, the velocities or the tick counter. If clear_in coincides with a hit capture, clear wins for hit_mask; the velocities are still captured.
- hit_count_out is a registered popcount of the next hit_mask value, so it is always consistent with hit_mask_out in the same cycle.
- Velocities are passed through unmodified as 16-bit values; no arithmetic is applied.

## Timing
- Tick in cycle T: coll_start_out is high at T+1 and COLL_WAIT begins at T+2.
- coll_done_in is sampled in cycle D: pins_vx/vy_out, hit_mask_out, hit_count_out and step_valid_out all change in D+1.
- Minimum frame latency from tick to step_valid_out is 3 cycles, with a zero-delay collision block (done at T+2).
- Handshake: step_valid_out stays high and the data stays stable until the cycle where valid and ready are both high. frame_count_out updates the cycle after that handshake.
- coll_done_in arriving in a state other than COLL_WAIT is ignored.
- Asynchronous reset mid-frame forces IDLE immediately. When rst_n_in deasserts, no start pulse is issued until a full FRAME_CYCLES has elapsed with run_in=1.

## Structure
- Shared physics package:
  - state enum physics_sched_state_t (IDLE, WAIT_TICK, COLL_REQ, COLL_WAIT, STEP)
  - NUM_PINS default
  - velocity width constant VEL_W=16
- Sub-module frame_timer: the tick counter, with inputs run_in and FRAME_CYCLES and output tick. Everything else stays in a single always_ff block plus next-state logic.

## Test plan
All scenarios use FRAME_CYCLES=8, COLL_TIMEOUT=4.
- Nominal frame: run_in=1; done 2 cycles after start with coll_hit_in=10'b0000000101, coll_vx_in[0]=16'h0040; step_ready_in tied to 1 → exactly one start pulse per 8 cycles; pins_vx_out[0]=0x0040; hit_mask_out=0x005; hit_count_out=2; frame_count_out=1.
- Sticky mask: second frame with coll_hit_in=0x004 → hit_mask_out stays 0x005, pins_vx_out[0] unchanged; third frame with coll_hit_in=0x200 → hit_mask_out=0x205, hit_count_out=3.
- Backpressure: step_ready_in held low for 12 cycles → step_valid_out held high with stable data; overrun_out=1; exactly one frame_count increment after ready rises.
- Timeout: coll_done_in never asserted → timeout_out=1 after 4 wait cycles; no step_valid_out; frame_count_out unchanged; next tick issues a new start pulse.
- Clear and run_in deassert: clear_in pulse → hit_mask_out=0, hit_count_out=0, frame_count_out=0, flags=0; drop run_in during COLL_WAIT → frame completes and the state is IDLE with no further starts.
- Async reset: assert rst_n_in low during STEP → all outputs 0 immediately, without waiting for a clock edge; first start pulse comes 8 cycles after reset release with run_in=1.
